tri_pixel_collector: RTL and testbench

Downstream consumer of the triangle rasterizer's point stream. It captures every asserted `po`/`xo`/`yo` point of one frame into an 8x8 bitmap and counts the distinct lit pixels. When the frame ends, it drains the bitmap one row at a time over a valid/ready handshake. It sits between the rasterizer and the display/compare logic and decouples the rasterizer's fixed 64-cycle scan from a back-pressured sink.

---
 rtl/tri_pixel_collector_if.sv | 22 ++
 rtl/tri_pixel_collector.sv | 144 ++++++++++++++
 tb/tb_tri_pixel_collector.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/tri_pixel_collector_if.sv
// Row-drain handshake between the pixel collector and its downstream sink.
// The collector presents one bitmap row per transfer; the sink throttles with row_ready.
interface tri_pixel_collector_if;
  logic       row_valid;
  logic [2:0] row_idx;
  logic [7:0] row_data;
  logic       row_ready;

  modport master (
    output row_valid,
    output row_idx,
    output row_data,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_idx,
    input  row_data,
    output row_ready
  );
endinterface

// File: rtl/tri_pixel_collector.sv
// Captures one rasterizer frame into an 8x8 bitmap, counts lit pixels and then
// drains the bitmap row by row over a valid/ready handshake.
module tri_pixel_collector #(
  parameter bit DUP_COUNT = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         busy_i,
  input  logic                         po,
  input  logic [2:0]                   xo,
  input  logic [2:0]                   yo,
  tri_pixel_collector_if.master        row_if,
  output logic [6:0]                   pix_cnt,
  output logic                         frame_busy,
  output logic                         done,
  output logic                         overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    TAIL    = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t          state_q;
  logic            busy_d_q;
  logic [7:0][7:0] bitmap_q;
  logic            row_valid_q;
  logic [2:0]      row_idx_q;
  logic [7:0]      row_data_q;
  logic [6:0]      pix_cnt_q;
  logic            frame_busy_q;
  logic            done_q;
  logic            overrun_q;

  logic            start_d;
  logic            count_en_d;
  logic [6:0]      cnt_max_d;
  logic [7:0]      row0_d;
  logic [2:0]      next_row_d;

  // Row 0 is loaded on the TAIL edge, so it must already include the TAIL pixel.
  always_comb begin
    start_d    = busy_i & ~busy_d_q;
    cnt_max_d  = DUP_COUNT ? 7'd127 : 7'd64;
    count_en_d = po & (DUP_COUNT | ~bitmap_q[yo][xo]) & (pix_cnt_q != cnt_max_d);
    if (po && (yo == 3'd0)) begin
      row0_d = bitmap_q[0] | (8'd1 << xo);
    end else begin
      row0_d = bitmap_q[0];
    end
    next_row_d = row_idx_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_d_q     <= 1'b0;
      bitmap_q     <= '0;
      row_valid_q  <= 1'b0;
      row_idx_q    <= 3'd0;
      row_data_q   <= 8'd0;
      pix_cnt_q    <= 7'd0;
      frame_busy_q <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      busy_d_q <= busy_i;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            bitmap_q     <= '0;
            pix_cnt_q    <= 7'd0;
            frame_busy_q <= 1'b1;
            state_q      <= COLLECT;
          end
        end
        COLLECT: begin
          if (po) begin
            bitmap_q[yo][xo] <= 1'b1;
          end
          if (count_en_d) begin
            pix_cnt_q <= pix_cnt_q + 7'd1;
          end
          if (!busy_i) begin
            state_q <= TAIL;
          end
        end
        TAIL: begin
          if (po) begin
            bitmap_q[yo][xo] <= 1'b1;
          end
          if (count_en_d) begin
            pix_cnt_q <= pix_cnt_q + 7'd1;
          end
          row_valid_q <= 1'b1;
          row_idx_q   <= 3'd0;
          row_data_q  <= row0_d;
          state_q     <= DRAIN;
        end
        DRAIN: begin
          // A frame starting now cannot be captured; it is dropped and flagged.
          if (start_d) begin
            overrun_q <= 1'b1;
          end
          if (row_valid_q && row_if.row_ready) begin
            if (row_idx_q == 3'd7) begin
              row_valid_q  <= 1'b0;
              row_idx_q    <= 3'd0;
              row_data_q   <= 8'd0;
              frame_busy_q <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= DONE;
            end else begin
              row_idx_q  <= next_row_d;
              row_data_q <= bitmap_q[next_row_d];
            end
          end
        end
        DONE: begin
          if (start_d) begin
            overrun_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign row_if.row_valid = row_valid_q;
  assign row_if.row_idx   = row_idx_q;
  assign row_if.row_data  = row_data_q;
  assign pix_cnt          = pix_cnt_q;
  assign frame_busy       = frame_busy_q;
  assign done             = done_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_tri_pixel_collector.sv
// Directed bench for tri_pixel_collector: a table of frames plus hand-written
// reset, saturation and overrun sequences; two instances cover both DUP_COUNT settings.
module tb_tri_pixel_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy_i = 1'b0;
  logic       po = 1'b0;
  logic [2:0] xo = 3'd0;
  logic [2:0] yo = 3'd0;
  logic       row_ready = 1'b1;

  logic [6:0] pix_cnt0, pix_cnt1;
  logic       frame_busy0, frame_busy1, done0, done1, overrun0, overrun1;

  int n_vec = 0;
  int n_bad = 0;

  tri_pixel_collector_if if0 ();
  tri_pixel_collector_if if1 ();
  assign if0.row_ready = row_ready;
  assign if1.row_ready = row_ready;

  tri_pixel_collector #(.DUP_COUNT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .busy_i(busy_i), .po(po), .xo(xo), .yo(yo),
    .row_if(if0.master), .pix_cnt(pix_cnt0), .frame_busy(frame_busy0),
    .done(done0), .overrun(overrun0)
  );

  tri_pixel_collector #(.DUP_COUNT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .busy_i(busy_i), .po(po), .xo(xo), .yo(yo),
    .row_if(if1.master), .pix_cnt(pix_cnt1), .frame_busy(frame_busy1),
    .done(done1), .overrun(overrun1)
  );

  always #5 clk = ~clk;

  // One frame: points as {y,x} octal pairs, optional TAIL point, expected rows {row7..row0}.
  typedef struct packed {
    logic [3:0]      npts;
    logic [3:0][5:0] pts;
    logic            tail_en;
    logic [5:0]      tail;
    logic [7:0][7:0] rows;
    logic [6:0]      c0;
    logic [6:0]      c1;
    logic [3:0]      stall_n;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] x, input logic [2:0] y, input logic v);
    po = v;
    xo = x;
    yo = y;
    tick();
    po = 1'b0;
  endtask

  task automatic begin_frame();
    busy_i = 1'b1;
    po     = 1'b0;
    tick();
    chk("frame_busy_at_s1", {31'd0, frame_busy0}, 32'd1);
  endtask

  // Leaves the bench at cycle F+2 (first row presented).
  task automatic run_collect(input vec_t v);
    int k;
    k = 0;
    begin_frame();
    for (int c = 0; c < 63; c++) begin
      if ((c % 8 == 3) && (k < int'(v.npts))) begin
        put(v.pts[k][2:0], v.pts[k][5:3], 1'b1);
        k++;
      end else begin
        put(3'd0, 3'd0, 1'b0);
      end
    end
    busy_i = 1'b0;
    put(3'd0, 3'd0, 1'b0);
    put(v.tail[2:0], v.tail[5:3], v.tail_en);
  endtask

  task automatic drain_check(input string tag, input logic [7:0][7:0] rows,
                             input logic [6:0] c0, input logic [6:0] c1,
                             input logic [3:0] stall_n);
    for (int r = 0; r < 8; r++) begin
      if (r == 2 && stall_n != 4'd0) begin
        row_ready = 1'b0;
        for (int s = 0; s < int'(stall_n); s++) begin
          chk($sformatf("%s_stall%0d_idx", tag, s), {29'd0, if0.row_idx}, 32'd2);
          chk($sformatf("%s_stall%0d_data", tag, s), {24'd0, if0.row_data}, {24'd0, rows[2]});
          chk($sformatf("%s_stall%0d_done", tag, s), {31'd0, done0}, 32'd0);
          tick();
        end
        row_ready = 1'b1;
      end
      chk($sformatf("%s_row%0d_valid", tag, r), {31'd0, if0.row_valid}, 32'd1);
      chk($sformatf("%s_row%0d_idx", tag, r), {29'd0, if0.row_idx}, r);
      chk($sformatf("%s_row%0d_data", tag, r), {24'd0, if0.row_data}, {24'd0, rows[r]});
      chk($sformatf("%s_row%0d_data_dup", tag, r), {24'd0, if1.row_data}, {24'd0, rows[r]});
      tick();
    end
    chk({tag, "_done"}, {31'd0, done0}, 32'd1);
    chk({tag, "_fbusy_off"}, {31'd0, frame_busy0}, 32'd0);
    chk({tag, "_valid_off"}, {31'd0, if0.row_valid}, 32'd0);
    chk({tag, "_idx_zero"}, {29'd0, if0.row_idx}, 32'd0);
    chk({tag, "_cnt0"}, {25'd0, pix_cnt0}, {25'd0, c0});
    chk({tag, "_cnt1"}, {25'd0, pix_cnt1}, {25'd0, c1});
    tick();
    chk({tag, "_done_1cyc"}, {31'd0, done0}, 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"}, {31'd0, if0.row_valid}, 32'd0);
    chk({tag, "_idx"}, {29'd0, if0.row_idx}, 32'd0);
    chk({tag, "_data"}, {24'd0, if0.row_data}, 32'd0);
    chk({tag, "_cnt0"}, {25'd0, pix_cnt0}, 32'd0);
    chk({tag, "_cnt1"}, {25'd0, pix_cnt1}, 32'd0);
    chk({tag, "_fbusy"}, {31'd0, frame_busy0}, 32'd0);
    chk({tag, "_done"}, {31'd0, done0}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun0}, 32'd0);
  endtask

  initial begin
    //           npts  pts {p3,p2,p1,p0} as {y,x}   tail_en tail   rows {r7..r0}              c0     c1     stall
    vecs[0] = '{4'd3, {6'o00, 6'o22, 6'o12, 6'o11}, 1'b0, 6'o00, 64'h0000_0000_0004_0600, 7'd3, 7'd3, 4'd0};
    vecs[1] = '{4'd0, {6'o00, 6'o00, 6'o00, 6'o00}, 1'b1, 6'o77, 64'h8000_0000_0000_0000, 7'd1, 7'd1, 4'd0};
    vecs[2] = '{4'd2, {6'o00, 6'o00, 6'o33, 6'o33}, 1'b0, 6'o00, 64'h0000_0000_0800_0000, 7'd1, 7'd2, 4'd0};
    vecs[3] = '{4'd0, {6'o00, 6'o00, 6'o00, 6'o00}, 1'b0, 6'o00, 64'h0000_0000_0000_0000, 7'd0, 7'd0, 4'd0};
    vecs[4] = '{4'd3, {6'o00, 6'o70, 6'o07, 6'o00}, 1'b1, 6'o04, 64'h0100_0000_0000_0091, 7'd4, 7'd4, 4'd0};
    vecs[5] = '{4'd1, {6'o00, 6'o00, 6'o00, 6'o00}, 1'b1, 6'o00, 64'h0000_0000_0000_0001, 7'd1, 7'd2, 4'd0};
    vecs[6] = '{4'd3, {6'o00, 6'o31, 6'o25, 6'o20}, 1'b0, 6'o00, 64'h0000_0000_0221_0000, 7'd3, 7'd3, 4'd5};

    tick();
    tick();
    reset = 1'b0;
    chk_reset_values("por");

    for (int i = 0; i < 7; i++) begin
      run_collect(vecs[i]);
      drain_check($sformatf("vec%0d", i), vecs[i].rows, vecs[i].c0, vecs[i].c1, vecs[i].stall_n);
      tick();
    end

    // Pulses far beyond 64 points: unique count stops at 64, duplicate count at 127.
    begin_frame();
    for (int c = 0; c < 140; c++) begin
      put(3'(c % 8), 3'((c / 8) % 8), 1'b1);
    end
    busy_i = 1'b0;
    put(3'd0, 3'd0, 1'b0);
    put(3'd0, 3'd0, 1'b0);
    drain_check("sat", 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 7'd127, 4'd0);
    tick();

    // busy_i rises while frame A drains: rows and count stay those of frame A.
    run_collect(vecs[0]);
    busy_i = 1'b1;
    drain_check("ovr", vecs[0].rows, vecs[0].c0, vecs[0].c1, 4'd0);
    chk("ovr_flag", {31'd0, overrun0}, 32'd1);
    tick();
    tick();
    busy_i = 1'b0;
    tick();
    tick();
    chk("ovr_sticky", {31'd0, overrun0}, 32'd1);
    chk("ovr_idle_fbusy", {31'd0, frame_busy0}, 32'd0);
    run_collect(vecs[2]);
    drain_check("post_ovr", vecs[2].rows, vecs[2].c0, vecs[2].c1, 4'd0);
    chk("ovr_sticky2", {31'd0, overrun0}, 32'd1);
    tick();

    // Reset for two cycles in the middle of collection.
    begin_frame();
    put(3'd3, 3'd4, 1'b1);
    put(3'd0, 3'd0, 1'b0);
    reset  = 1'b1;
    busy_i = 1'b0;
    tick();
    chk_reset_values("rst_c1");
    tick();
    reset = 1'b0;
    chk_reset_values("rst_c2");
    tick();
    chk_reset_values("rst_idle");
    run_collect(vecs[4]);
    drain_check("post_rst", vecs[4].rows, vecs[4].c0, vecs[4].c1, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
